// File: rtl/ibex_cheri_cap_seq.sv
// ibex_cheri_cap_seq
// Capability-width (64-bit data + tag) load/store sequencer for the CHERI Ibex
// LSU path. One capability access is first checked by the CHERI memory checker.
// If the checker is clean, the access is issued as two 32-bit OBI word beats,
// low word first.
//
// Optional feature: define IBEX_CHERI_CAPSEQ_WDOG_EN to build a bus-wait
// watchdog. The watchdog aborts an access after WdogCycles cycles spent without
// progress in a bus state. Without the macro, bus waits are unbounded.

package ibex_cheri_cap_seq_pkg;

    // Exception vector reported by the CHERI memory checker
    typedef struct packed {
        logic tag_violation;
        logic seal_violation;
        logic perm_violation;
        logic length_violation;
        logic align_violation;
    } cheri_exc_t;

endpackage

module ibex_cheri_cap_seq
    import ibex_cheri_cap_seq_pkg::*;
#(
    parameter int unsigned WdogCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req_i,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    input  logic        req_wtag_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] rdata_o,
    output logic        rtag_o,
    output logic        exc_o,
    output cheri_exc_t  exc_cause_o,
    output logic        err_o,

    output logic [31:0] chk_addr_o,
    output logic        chk_we_o,
    output logic [1:0]  chk_type_o,
    output logic [3:0]  chk_be_o,
    output logic        chk_cap_o,
    input  cheri_exc_t  chk_exc_i,

    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    output logic        data_wtag_o,
    input  logic [31:0] data_rdata_i,
    input  logic        data_rtag_i
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LO_REQ,
        LO_RESP,
        HI_REQ,
        HI_RESP
    } state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic        we_q;
    logic [63:0] wdata_q;
    logic        wtag_q;
    logic        lo_tag_q;
    logic        done_q;
    logic        exc_q;
    logic        err_q;
    logic [63:0] rdata_q;
    logic        rtag_q;
    cheri_exc_t  cause_q;
    logic        hi_phase;
    logic        wdog_expire;

`ifdef IBEX_CHERI_CAPSEQ_WDOG_EN
    localparam logic [16:0] WdogLimit = 17'(WdogCycles);

    logic [15:0] wdog_q;
    logic [16:0] wdog_next;
    logic        bus_state;
    logic        bus_step;

    assign bus_state = (state_q == LO_REQ) || (state_q == LO_RESP) ||
                       (state_q == HI_REQ) || (state_q == HI_RESP);
    assign bus_step  = (((state_q == LO_REQ)  || (state_q == HI_REQ))  && data_gnt_i) ||
                       (((state_q == LO_RESP) || (state_q == HI_RESP)) && data_rvalid_i);
    assign wdog_next   = {1'b0, wdog_q} + 17'd1;
    assign wdog_expire = bus_state && !bus_step && (wdog_next == WdogLimit);

    // Count cycles spent waiting in a bus state; any state change restarts the count
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wdog_q <= '0;
        end else if (!bus_state || bus_step || wdog_expire) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_next[15:0];
        end
    end
`else
    logic unused_wdog_cfg;

    assign wdog_expire     = 1'b0;
    assign unused_wdog_cfg = |WdogCycles;
`endif

    // Main sequencer: accept, check, two word beats, registered completion
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wtag_q   <= 1'b0;
            lo_tag_q <= 1'b0;
            done_q   <= 1'b0;
            exc_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rtag_q   <= 1'b0;
            cause_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_i) begin
                        addr_q  <= {req_addr_i[31:3], 3'b000};
                        we_q    <= req_we_i;
                        wdata_q <= req_wdata_i;
                        wtag_q  <= req_wtag_i;
                        exc_q   <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (|chk_exc_i) begin
                        cause_q <= chk_exc_i;
                        exc_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        state_q <= LO_REQ;
                    end
                end
                LO_REQ: begin
                    if (data_gnt_i) begin
                        state_q <= LO_RESP;
                    end else if (wdog_expire) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                LO_RESP: begin
                    if (data_rvalid_i) begin
                        if (!we_q) begin
                            rdata_q[31:0] <= data_rdata_i;
                        end
                        lo_tag_q <= data_rtag_i;
                        if (data_err_i) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            state_q <= HI_REQ;
                        end
                    end else if (wdog_expire) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                HI_REQ: begin
                    if (data_gnt_i) begin
                        state_q <= HI_RESP;
                    end else if (wdog_expire) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                HI_RESP: begin
                    if (data_rvalid_i) begin
                        if (!we_q) begin
                            rdata_q[63:32] <= data_rdata_i;
                            rtag_q         <= lo_tag_q & data_rtag_i;
                        end
                        err_q   <= data_err_i;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (wdog_expire) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The latched address is 8-byte aligned, so the high beat just sets bit 2
    assign hi_phase = (state_q == HI_REQ) || (state_q == HI_RESP);

    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign rdata_o     = rdata_q;
    assign rtag_o      = rtag_q;
    assign exc_o       = exc_q;
    assign exc_cause_o = cause_q;
    assign err_o       = err_q;

    assign chk_addr_o = addr_q;
    assign chk_we_o   = we_q;
    assign chk_type_o = 2'b11;
    assign chk_be_o   = 4'hF;
    assign chk_cap_o  = 1'b1;

    assign data_req_o   = (state_q == LO_REQ) || (state_q == HI_REQ);
    assign data_addr_o  = {addr_q[31:3], hi_phase, 2'b00};
    assign data_we_o    = we_q;
    assign data_be_o    = 4'hF;
    assign data_wdata_o = hi_phase ? wdata_q[63:32] : wdata_q[31:0];
    assign data_wtag_o  = wtag_q;

endmodule

// File: tb/tb_ibex_cheri_cap_seq.sv
// tb_ibex_cheri_cap_seq
// Self-checking bench for ibex_cheri_cap_seq. The bench plays the role of the
// LSU, the checker and an OBI memory with configurable grant/response delays.
// Build with IBEX_CHERI_CAPSEQ_WDOG_EN defined to exercise the watchdog.

module tb_ibex_cheri_cap_seq;
    import ibex_cheri_cap_seq_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic        wtag;
        logic [4:0]  exc;
        int          gd0, gd1, rd0, rd1;
        logic [31:0] lo_rd, hi_rd;
        logic        lo_tag, hi_tag, lo_err, hi_err;
        int          budget;
        bit          abort_hi;
    } access_t;

    typedef struct {
        bit               done;
        int               latency;
        logic [63:0]      rdata;
        logic             rtag, exc, err;
        logic [4:0]       cause;
        int               nreq;
        int               unstable;
        int               overlap;
        logic [1:0][31:0] baddr, bwdata;
        logic [1:0]       bwe, bwtag, bbe_ok;
        logic [31:0]      chk_addr;
        logic             chk_we;
        logic [6:0]       chk_const;
        logic             busy_on_done, busy_end, req_end;
        bit               reset_applied;
    } result_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0, req_we_i = 1'b0, req_wtag_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [63:0] req_wdata_i = '0;
    logic        busy_o, done_o, rtag_o, exc_o, err_o;
    logic [63:0] rdata_o;
    cheri_exc_t  exc_cause_o;
    logic [31:0] chk_addr_o;
    logic        chk_we_o, chk_cap_o;
    logic [1:0]  chk_type_o;
    logic [3:0]  chk_be_o;
    cheri_exc_t  chk_exc_i = '0;
    logic        data_req_o, data_we_o, data_wtag_o;
    logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0, data_err_i = 1'b0, data_rtag_i = 1'b0;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_rdata_i = '0;

    int checks = 0;
    int passed = 0;

    always #5 clk_i = ~clk_i;

    ibex_cheri_cap_seq #(.WdogCycles(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_i(req_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_wtag_i(req_wtag_i),
        .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o), .rtag_o(rtag_o),
        .exc_o(exc_o), .exc_cause_o(exc_cause_o), .err_o(err_o),
        .chk_addr_o(chk_addr_o), .chk_we_o(chk_we_o), .chk_type_o(chk_type_o),
        .chk_be_o(chk_be_o), .chk_cap_o(chk_cap_o), .chk_exc_i(chk_exc_i),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_err_i(data_err_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_wtag_o(data_wtag_o),
        .data_rdata_i(data_rdata_i), .data_rtag_i(data_rtag_i)
    );

    // Default access: zero-wait load with no errors and no checker exception
    function automatic access_t base_access(input logic we, input logic [31:0] addr);
        access_t a;
        a.we = we; a.addr = addr; a.wdata = '0; a.wtag = 1'b0; a.exc = '0;
        a.gd0 = 0; a.gd1 = 0; a.rd0 = 0; a.rd1 = 0;
        a.lo_rd = '0; a.hi_rd = '0; a.lo_tag = 1'b0; a.hi_tag = 1'b0;
        a.lo_err = 1'b0; a.hi_err = 1'b0; a.budget = 200; a.abort_hi = 1'b0;
        return a;
    endfunction

    // Reference model: expected outcome of one access from the access rules
    function automatic result_t model_access(input access_t a, input logic [63:0] prev_rdata,
                                             input logic prev_rtag, input logic [4:0] prev_cause);
        result_t e;
        logic [31:0] base;
        e = '{default: '0};
        base = a.addr & 32'hFFFF_FFF8;
        e.done = 1; e.rdata = prev_rdata; e.rtag = prev_rtag; e.cause = prev_cause;
        e.chk_addr = base; e.chk_we = a.we;
        if (a.exc != 5'd0) begin
            e.exc = 1'b1; e.cause = a.exc; e.latency = 2;
            return e;
        end
        e.nreq = a.lo_err ? 1 : 2;
        e.baddr[0] = base; e.baddr[1] = base + 32'd4;
        e.bwdata[0] = a.wdata[31:0]; e.bwdata[1] = a.wdata[63:32];
        e.latency = 1 + (a.gd0 + 1) + (a.rd0 + 1) + 1;
        if (!a.lo_err) e.latency += (a.gd1 + 1) + (a.rd1 + 1);
        if (!a.we) begin
            e.rdata[31:0] = a.lo_rd;
            if (!a.lo_err) begin
                e.rdata[63:32] = a.hi_rd;
                e.rtag = a.lo_tag & a.hi_tag;
            end
        end
        e.err = a.lo_err ? 1'b1 : a.hi_err;
        return e;
    endfunction

    // Drive one access and act as checker plus memory until done or budget expiry
    task automatic run_access(input access_t a, output result_t r);
        int  gwait, rwait, gbeat, rbeat;
        bit  active, pend;
        logic [65:0] cur;
        r = '{default: '0};
        gwait = 0; rwait = 0; gbeat = 0; rbeat = 0; active = 0; pend = 0; cur = '0;
        req_i = 1'b1; req_we_i = a.we; req_addr_i = a.addr;
        req_wdata_i = a.wdata; req_wtag_i = a.wtag;
        chk_exc_i = cheri_exc_t'(a.exc);
        for (int cyc = 1; cyc <= a.budget; cyc++) begin
            @(posedge clk_i); #1;
            data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
            if (cyc == 1) begin
                r.chk_addr = chk_addr_o; r.chk_we = chk_we_o;
                r.chk_const = {chk_type_o, chk_be_o, chk_cap_o};
            end
            if (done_o) begin
                r.done = 1; r.latency = cyc; r.rdata = rdata_o; r.rtag = rtag_o;
                r.exc = exc_o; r.err = err_o; r.cause = exc_cause_o; r.busy_on_done = busy_o;
                break;
            end
            if (pend) begin
                if (rwait == 0) begin
                    if (a.abort_hi && rbeat == 1) begin
                        rst_ni = 1'b0; r.reset_applied = 1;
                        break;
                    end
                    data_rvalid_i = 1'b1;
                    data_rdata_i = (rbeat == 0) ? a.lo_rd : a.hi_rd;
                    data_rtag_i  = (rbeat == 0) ? a.lo_tag : a.hi_tag;
                    data_err_i   = (rbeat == 0) ? a.lo_err : a.hi_err;
                    pend = 0; rbeat++;
                end else begin
                    rwait--;
                end
            end
            if (data_req_o) begin
                if (pend) r.overlap++;
                if (!active) begin
                    active = 1;
                    gwait = (gbeat == 0) ? a.gd0 : a.gd1;
                    cur = {data_addr_o, data_wdata_o, data_we_o, data_wtag_o};
                    if (r.nreq < 2) begin
                        r.baddr[r.nreq] = data_addr_o; r.bwdata[r.nreq] = data_wdata_o;
                        r.bwe[r.nreq] = data_we_o; r.bwtag[r.nreq] = data_wtag_o;
                        r.bbe_ok[r.nreq] = (data_be_o == 4'hF);
                    end
                    r.nreq++;
                end else if ({data_addr_o, data_wdata_o, data_we_o, data_wtag_o} !== cur) begin
                    r.unstable++;
                end
                if (gwait == 0) begin
                    data_gnt_i = 1'b1; active = 0; pend = 1;
                    rwait = (gbeat == 0) ? a.rd0 : a.rd1;
                    gbeat++;
                end else begin
                    gwait--;
                end
            end
        end
        r.busy_end = busy_o; r.req_end = data_req_o;
        req_i = 1'b0; chk_exc_i = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy_o, done_o, exc_o, err_o, data_req_o, rtag_o} !== 6'b0)
            $display("[TB] FAIL reset_flags: got %b expected 000000", {busy_o, done_o, exc_o, err_o, data_req_o, rtag_o});
        else passed++;
        checks++;
        if (rdata_o !== 64'd0 || exc_cause_o !== 5'd0)
            $display("[TB] FAIL reset_data: got rdata %h cause %b expected 0", rdata_o, exc_cause_o);
        else passed++;
    endtask

    task automatic test_load_zero_wait();
        access_t a; result_t r;
        a = base_access(1'b0, 32'h0000_1000);
        a.lo_rd = 32'hDEADBEEF; a.lo_tag = 1'b1; a.hi_rd = 32'h01234567; a.hi_tag = 1'b1;
        run_access(a, r);
        checks++;
        if (!r.done || r.latency != 6)
            $display("[TB] FAIL load_latency: got done %0d latency %0d expected 1/6", r.done, r.latency);
        else passed++;
        checks++;
        if (r.rdata !== 64'h01234567_DEADBEEF || r.rtag !== 1'b1)
            $display("[TB] FAIL load_data: got %h tag %b expected 01234567deadbeef tag 1", r.rdata, r.rtag);
        else passed++;
        checks++;
        if (r.nreq != 2 || r.baddr[0] !== 32'h1000 || r.baddr[1] !== 32'h1004 || r.busy_on_done !== 1'b0)
            $display("[TB] FAIL load_beats: got n %0d addr %h %h busy %b expected 2 1000 1004 0",
                     r.nreq, r.baddr[0], r.baddr[1], r.busy_on_done);
        else passed++;
        checks++;
        if (r.chk_addr !== 32'h1000 || r.chk_we !== 1'b0 || r.chk_const !== 7'b11_1111_1)
            $display("[TB] FAIL load_chk: got %h %b %b expected 00001000 0 1111111", r.chk_addr, r.chk_we, r.chk_const);
        else passed++;
    endtask

    task automatic test_exception();
        access_t a; result_t r;
        cheri_exc_t cause;
        cause = '0; cause.length_violation = 1'b1;
        a = base_access(1'b0, 32'h0000_3007);
        a.exc = 5'(cause);
        run_access(a, r);
        checks++;
        if (!r.done || r.latency != 2 || r.exc !== 1'b1 || r.err !== 1'b0)
            $display("[TB] FAIL exc_done: got done %0d lat %0d exc %b err %b expected 1 2 1 0", r.done, r.latency, r.exc, r.err);
        else passed++;
        checks++;
        if (r.cause !== 5'(cause) || r.nreq != 0)
            $display("[TB] FAIL exc_cause: got %b nreq %0d expected %b 0", r.cause, r.nreq, 5'(cause));
        else passed++;
        checks++;
        if (r.chk_addr !== 32'h3000)
            $display("[TB] FAIL exc_chk_addr: got %h expected 00003000", r.chk_addr);
        else passed++;
    endtask

    task automatic test_store_delayed();
        access_t a; result_t r;
        a = base_access(1'b1, 32'h0000_2008);
        a.wdata = 64'hAAAA5555_11112222; a.wtag = 1'b1; a.gd0 = 3; a.gd1 = 3;
        run_access(a, r);
        checks++;
        if (!r.done || r.latency != 12 || r.err !== 1'b0)
            $display("[TB] FAIL store_done: got done %0d lat %0d err %b expected 1 12 0", r.done, r.latency, r.err);
        else passed++;
        checks++;
        if (r.nreq != 2 || r.baddr[0] !== 32'h2008 || r.bwdata[0] !== 32'h11112222 ||
            r.baddr[1] !== 32'h200C || r.bwdata[1] !== 32'hAAAA5555)
            $display("[TB] FAIL store_beats: got %0d %h:%h %h:%h expected 2 2008:11112222 200c:aaaa5555",
                     r.nreq, r.baddr[0], r.bwdata[0], r.baddr[1], r.bwdata[1]);
        else passed++;
        checks++;
        if (r.bwe !== 2'b11 || r.bwtag !== 2'b11 || r.bbe_ok !== 2'b11 || r.unstable != 0 || r.overlap != 0)
            $display("[TB] FAIL store_signals: got we %b tag %b be %b unstable %0d overlap %0d expected 11 11 11 0 0",
                     r.bwe, r.bwtag, r.bbe_ok, r.unstable, r.overlap);
        else passed++;
    endtask

    task automatic test_bus_error();
        access_t a; result_t r;
        a = base_access(1'b0, 32'h0000_4000);
        a.lo_err = 1'b1; a.lo_rd = 32'h1234_5678;
        run_access(a, r);
        checks++;
        if (!r.done || r.err !== 1'b1 || r.exc !== 1'b0 || r.nreq != 1)
            $display("[TB] FAIL bus_error: got done %0d err %b exc %b nreq %0d expected 1 1 0 1", r.done, r.err, r.exc, r.nreq);
        else passed++;
    endtask

    task automatic test_tag_and();
        access_t a; result_t r;
        a = base_access(1'b0, 32'h0000_5000);
        a.lo_rd = 32'h0BAD_F00D; a.lo_tag = 1'b1; a.hi_rd = 32'hCAFE_0001; a.hi_tag = 1'b0;
        run_access(a, r);
        checks++;
        if (r.rtag !== 1'b0 || r.rdata !== 64'hCAFE0001_0BADF00D)
            $display("[TB] FAIL tag_and: got %h tag %b expected cafe00010badf00d tag 0", r.rdata, r.rtag);
        else passed++;
    endtask

    task automatic test_back_to_back();
        access_t a; result_t r1, r2;
        a = base_access(1'b0, 32'hFFFF_FFF8);
        a.lo_rd = 32'h1111_0000; a.hi_rd = 32'h2222_0000; a.lo_tag = 1'b1; a.hi_tag = 1'b1;
        run_access(a, r1);
        a.addr = 32'h0000_6000; a.lo_rd = 32'h3333_0000; a.hi_rd = 32'h4444_0000;
        run_access(a, r2);
        checks++;
        if (r1.baddr[1] !== 32'hFFFF_FFFC || r1.rdata !== 64'h22220000_11110000)
            $display("[TB] FAIL wrap_addr: got %h data %h expected fffffffc 2222000011110000", r1.baddr[1], r1.rdata);
        else passed++;
        checks++;
        if (!r2.done || r2.latency != 6 || r2.rdata !== 64'h44440000_33330000)
            $display("[TB] FAIL back_to_back: got done %0d lat %0d data %h expected 1 6 4444000033330000",
                     r2.done, r2.latency, r2.rdata);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        access_t a; result_t r;
        int dones, busies;
        a = base_access(1'b0, 32'h0000_7000);
        a.lo_tag = 1'b1; a.hi_tag = 1'b1; a.abort_hi = 1'b1;
        a.lo_rd = 32'h5555_5555; a.hi_rd = 32'h6666_6666;
        do_reset();
        run_access(a, r);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        checks++;
        if (!r.reset_applied || busy_o !== 1'b0 || data_req_o !== 1'b0 || done_o !== 1'b0)
            $display("[TB] FAIL reset_mid_op: got reached %0d busy %b req %b done %b expected 1 0 0 0",
                     r.reset_applied, busy_o, data_req_o, done_o);
        else passed++;
        dones = 0; busies = 0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h7777_7777; data_rtag_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            if (done_o) dones++;
            if (busy_o) busies++;
        end
        data_rvalid_i = 1'b0;
        checks++;
        if (dones != 0 || busies != 0 || rdata_o !== 64'd0 || rtag_o !== 1'b0)
            $display("[TB] FAIL stale_rvalid: got dones %0d busy %0d data %h tag %b expected 0 0 0 0",
                     dones, busies, rdata_o, rtag_o);
        else passed++;
    endtask

    task automatic test_watchdog();
        access_t a; result_t r;
        a = base_access(1'b0, 32'h0000_8000);
        a.gd0 = 1000000;
`ifdef IBEX_CHERI_CAPSEQ_WDOG_EN
        a.budget = 100;
        run_access(a, r);
        checks++;
        if (!r.done || r.err !== 1'b1 || r.exc !== 1'b0 || r.nreq != 1 || data_req_o !== 1'b0)
            $display("[TB] FAIL watchdog: got done %0d err %b exc %b nreq %0d req %b expected 1 1 0 1 0",
                     r.done, r.err, r.exc, r.nreq, data_req_o);
        else passed++;
`else
        a.budget = 1000;
        run_access(a, r);
        checks++;
        if (r.done || r.busy_end !== 1'b1 || r.req_end !== 1'b1)
            $display("[TB] FAIL no_watchdog: got done %0d busy %b req %b expected 0 1 1", r.done, r.busy_end, r.req_end);
        else passed++;
`endif
        do_reset();
    endtask

    task automatic test_random();
        access_t a; result_t r, e;
        logic [63:0] m_rdata;
        logic        m_rtag;
        logic [4:0]  m_cause;
        do_reset();
        m_rdata = '0; m_rtag = 1'b0; m_cause = '0;
        for (int n = 0; n < 30; n++) begin
            a = base_access(1'($urandom_range(0, 1)), $urandom);
            if (n == 5) a.addr = 32'hFFFF_FFFF;
            a.wdata = {$urandom, $urandom}; a.wtag = 1'($urandom_range(0, 1));
            a.exc = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            a.gd0 = $urandom_range(0, 3); a.gd1 = $urandom_range(0, 3);
            a.rd0 = $urandom_range(0, 3); a.rd1 = $urandom_range(0, 3);
            a.lo_rd = $urandom; a.hi_rd = $urandom;
            a.lo_tag = 1'($urandom_range(0, 1)); a.hi_tag = 1'($urandom_range(0, 1));
            a.lo_err = ($urandom_range(0, 7) == 0); a.hi_err = ($urandom_range(0, 7) == 0);
            e = model_access(a, m_rdata, m_rtag, m_cause);
            run_access(a, r);
            checks++;
            if (r.done != e.done || r.latency != e.latency)
                $display("[TB] FAIL rand%0d_timing: got done %0d lat %0d expected %0d %0d", n, r.done, r.latency, e.done, e.latency);
            else passed++;
            checks++;
            if (r.exc !== e.exc || r.err !== e.err || r.cause !== e.cause)
                $display("[TB] FAIL rand%0d_status: got exc %b err %b cause %b expected %b %b %b",
                         n, r.exc, r.err, r.cause, e.exc, e.err, e.cause);
            else passed++;
            checks++;
            if (r.rdata !== e.rdata || r.rtag !== e.rtag)
                $display("[TB] FAIL rand%0d_rdata: got %h tag %b expected %h tag %b", n, r.rdata, r.rtag, e.rdata, e.rtag);
            else passed++;
            checks++;
            if (r.nreq != e.nreq || r.unstable != 0 || r.overlap != 0 || r.chk_addr !== e.chk_addr || r.chk_we !== e.chk_we)
                $display("[TB] FAIL rand%0d_bus: got n %0d unst %0d ovl %0d chk %h/%b expected %0d 0 0 %h/%b",
                         n, r.nreq, r.unstable, r.overlap, r.chk_addr, r.chk_we, e.nreq, e.chk_addr, e.chk_we);
            else passed++;
            for (int b = 0; b < e.nreq && b < r.nreq; b++) begin
                checks++;
                if (r.baddr[b] !== e.baddr[b] || r.bwe[b] !== a.we || r.bwtag[b] !== a.wtag ||
                    (a.we && r.bwdata[b] !== e.bwdata[b]))
                    $display("[TB] FAIL rand%0d_beat%0d: got %h:%h we %b tag %b expected %h:%h we %b tag %b",
                             n, b, r.baddr[b], r.bwdata[b], r.bwe[b], r.bwtag[b], e.baddr[b], e.bwdata[b], a.we, a.wtag);
                else passed++;
            end
            m_rdata = e.rdata; m_rtag = e.rtag; m_cause = e.cause;
            if (!r.done) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_load_zero_wait();
        test_exception();
        test_store_delayed();
        test_bus_error();
        test_tag_and();
        test_back_to_back();
        test_reset_mid_op();
        test_watchdog();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
